// File: rtl/cpu.sv
// Single-cycle MIPS32 subset CPU: pc, imem, rfile and dmem instances, glued by combinational decode/execute.
// Optional bne support (opcode 0x05) is enabled by defining CPU_BNE_EN.
module cpu_pc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] count_d,
    output logic [31:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= 32'h0;
        else        count <= count_d;
    end
endmodule

module cpu_imem (
    input  logic        clk,
    input  logic        wr_en,
    input  logic [5:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [5:0]  rd_addr,
    output logic [31:0] rd_data
);
    logic [31:0] memory [0:63];
    logic [31:0] words  [0:63];

    // Contents are preloaded through hierarchy; the write port is tied off at the top.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            memory[wr_addr] <= wr_data;
            words[wr_addr]  <= wr_data;
        end
    end

    assign rd_data = memory[rd_addr];
endmodule

module cpu_rfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] register [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) register[i] <= 32'h0;
        end else if (we && wa != 5'd0) begin
            register[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : register[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : register[ra2];
endmodule

module cpu_dmem (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [7:0] dataMemory [0:31];

    // Memory is not reset, but no store may land while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && we) begin
            dataMemory[addr]        <= wdata[7:0];
            dataMemory[addr + 5'd1] <= wdata[15:8];
            dataMemory[addr + 5'd2] <= wdata[23:16];
            dataMemory[addr + 5'd3] <= wdata[31:24];
        end
    end

    assign rdata = {dataMemory[addr + 5'd3], dataMemory[addr + 5'd2],
                    dataMemory[addr + 5'd1], dataMemory[addr]};
endmodule

module cpu (
    input  logic clk,
    input  logic rst_n
);
    logic [31:0] pc_count, count_d, pc_plus4, br_target, sext;
    logic [31:0] instr, rs_val, rt_val, wd, mem_rdata;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, wa, mem_sum, mem_addr;
    logic [15:0] imm;
    logic [25:0] target;
    logic        reg_we, mem_we;

    cpu_pc pc (.clk(clk), .rst_n(rst_n), .count_d(count_d), .count(pc_count));

    cpu_imem imem (.clk(clk), .wr_en(1'b0), .wr_addr(6'd0), .wr_data(32'h0),
                   .rd_addr(pc_count[7:2]), .rd_data(instr));

    cpu_rfile rfile (.clk(clk), .rst_n(rst_n), .ra1(rs), .ra2(rt), .rd1(rs_val), .rd2(rt_val),
                     .we(reg_we), .wa(wa), .wd(wd));

    cpu_dmem dmem (.clk(clk), .rst_n(rst_n), .we(mem_we), .addr(mem_addr), .wdata(rt_val),
                   .rdata(mem_rdata));

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign imm    = instr[15:0];
    assign funct  = instr[5:0];
    assign target = instr[25:0];

    always_comb begin
        pc_plus4  = pc_count + 32'd4;
        sext      = {{16{imm[15]}}, imm};
        br_target = pc_plus4 + {sext[29:0], 2'b00};
        // Only the low 5 address bits matter in a 32-byte memory; accesses are word aligned.
        mem_sum   = rs_val[4:0] + imm[4:0];
        mem_addr  = mem_sum & 5'b11100;
        count_d   = pc_plus4;
        reg_we    = 1'b0;
        mem_we    = 1'b0;
        wa        = rd;
        wd        = 32'h0;
        case (opcode)
            6'h00: begin
                reg_we = 1'b1;
                case (funct)
                    6'h20:   wd = rs_val + rt_val;
                    6'h22:   wd = rs_val - rt_val;
                    6'h24:   wd = rs_val & rt_val;
                    6'h25:   wd = rs_val | rt_val;
                    6'h2A:   wd = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    default: reg_we = 1'b0;
                endcase
            end
            6'h08: begin
                reg_we = 1'b1;
                wa     = rt;
                wd     = rs_val + sext;
            end
            6'h23: begin
                reg_we = 1'b1;
                wa     = rt;
                wd     = mem_rdata;
            end
            6'h2B: mem_we = 1'b1;
            6'h04: if (rs_val == rt_val) count_d = br_target;
`ifdef CPU_BNE_EN
            6'h05: if (rs_val != rt_val) count_d = br_target;
`endif
            6'h02: count_d = {pc_plus4[31:28], target, 2'b00};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: programs are preloaded through hierarchy and state is checked via hierarchy.
`timescale 1ns/1ps
module tb_cpu;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   nvec  = 0;
    int   nfail = 0;

    cpu dut (.clk(clk), .rst_n(rst_n));

    always #5 clk = ~clk;

    task automatic hold_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 64; i++) dut.imem.memory[i] = 32'h0;
        for (int i = 0; i < 32; i++) dut.dmem.dataMemory[i] = 8'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] dword(input int a);
        return {dut.dmem.dataMemory[a+3], dut.dmem.dataMemory[a+2],
                dut.dmem.dataMemory[a+1], dut.dmem.dataMemory[a]};
    endfunction

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        nvec++; if (dut.pc.count !== 32'h0) begin nfail++; $display("FAIL reset_pc got %h want %h", dut.pc.count, 32'h0); end
        nvec++; if (dut.rfile.register[8] !== 32'h0) begin nfail++; $display("FAIL reset_r8 got %h want %h", dut.rfile.register[8], 32'h0); end
        nvec++; if (dut.rfile.register[31] !== 32'h0) begin nfail++; $display("FAIL reset_r31 got %h want %h", dut.rfile.register[31], 32'h0); end
    endtask

    task automatic test_load_store();
        hold_reset();
        dut.dmem.dataMemory[0] = 8'd5;
        dut.imem.memory[0] = 32'h8C080000;  // lw   $t0,0($zero)
        dut.imem.memory[1] = 32'h21090003;  // addi $t1,$t0,3
        dut.imem.memory[2] = 32'hAC090004;  // sw   $t1,4($zero)
        release_reset();
        run(1);
        nvec++; if (dut.pc.count !== 32'h4) begin nfail++; $display("FAIL ls_first_pc got %h want %h", dut.pc.count, 32'h4); end
        run(2);
        nvec++; if (dut.rfile.register[8] !== 32'd5) begin nfail++; $display("FAIL ls_t0 got %h want %h", dut.rfile.register[8], 32'd5); end
        nvec++; if (dut.rfile.register[9] !== 32'd8) begin nfail++; $display("FAIL ls_t1 got %h want %h", dut.rfile.register[9], 32'd8); end
        nvec++; if (dword(4) !== 32'd8) begin nfail++; $display("FAIL ls_word4 got %h want %h", dword(4), 32'd8); end
        nvec++; if (dut.pc.count !== 32'd12) begin nfail++; $display("FAIL ls_pc got %h want %h", dut.pc.count, 32'd12); end
    endtask

    task automatic test_alu();
        hold_reset();
        dut.imem.memory[0] = 32'h2008FFFF;  // addi $t0,$zero,-1
        dut.imem.memory[1] = 32'h0100482A;  // slt  $t1,$t0,$zero
        dut.imem.memory[2] = 32'h00085022;  // sub  $t2,$zero,$t0
        dut.imem.memory[3] = 32'h010A5820;  // add  $t3,$t0,$t2
        dut.imem.memory[4] = 32'h01096024;  // and  $t4,$t0,$t1
        dut.imem.memory[5] = 32'h012A6825;  // or   $t5,$t1,$t2
        dut.imem.memory[6] = 32'h0008702A;  // slt  $t6,$zero,$t0
        release_reset();
        run(7);
        nvec++; if (dut.rfile.register[8] !== 32'hFFFFFFFF) begin nfail++; $display("FAIL alu_t0 got %h want %h", dut.rfile.register[8], 32'hFFFFFFFF); end
        nvec++; if (dut.rfile.register[9] !== 32'd1) begin nfail++; $display("FAIL alu_slt got %h want %h", dut.rfile.register[9], 32'd1); end
        nvec++; if (dut.rfile.register[10] !== 32'd1) begin nfail++; $display("FAIL alu_sub got %h want %h", dut.rfile.register[10], 32'd1); end
        nvec++; if (dut.rfile.register[11] !== 32'd0) begin nfail++; $display("FAIL alu_add_wrap got %h want %h", dut.rfile.register[11], 32'd0); end
        nvec++; if (dut.rfile.register[12] !== 32'd1) begin nfail++; $display("FAIL alu_and got %h want %h", dut.rfile.register[12], 32'd1); end
        nvec++; if (dut.rfile.register[13] !== 32'd1) begin nfail++; $display("FAIL alu_or got %h want %h", dut.rfile.register[13], 32'd1); end
        nvec++; if (dut.rfile.register[14] !== 32'd0) begin nfail++; $display("FAIL alu_slt_signed got %h want %h", dut.rfile.register[14], 32'd0); end
    endtask

    task automatic test_zero_reg();
        hold_reset();
        dut.imem.memory[0] = 32'h20000007;  // addi $zero,$zero,7
        dut.imem.memory[1] = 32'h0000403F;  // undefined funct, rd=$t0
        dut.imem.memory[2] = 32'h3C080001;  // undefined opcode, rt=$t0
        release_reset();
        run(3);
        nvec++; if (dut.rfile.register[0] !== 32'h0) begin nfail++; $display("FAIL zero_r0 got %h want %h", dut.rfile.register[0], 32'h0); end
        nvec++; if (dut.rfile.register[8] !== 32'h0) begin nfail++; $display("FAIL nop_r8 got %h want %h", dut.rfile.register[8], 32'h0); end
        nvec++; if (dut.pc.count !== 32'd12) begin nfail++; $display("FAIL nop_pc got %h want %h", dut.pc.count, 32'd12); end
    endtask

    task automatic test_branch_jump();
        hold_reset();
        dut.imem.memory[2] = 32'h1000FFFF;  // beq $zero,$zero,-1 at 0x08
        release_reset();
        run(2);
        nvec++; if (dut.pc.count !== 32'h8) begin nfail++; $display("FAIL beq_reach got %h want %h", dut.pc.count, 32'h8); end
        for (int i = 0; i < 3; i++) begin
            run(1);
            nvec++; if (dut.pc.count !== 32'h8) begin nfail++; $display("FAIL beq_loop%0d got %h want %h", i, dut.pc.count, 32'h8); end
        end
        hold_reset();
        dut.imem.memory[4] = 32'h08000000;  // j 0 at 0x10
        release_reset();
        run(4);
        nvec++; if (dut.pc.count !== 32'h10) begin nfail++; $display("FAIL j_reach got %h want %h", dut.pc.count, 32'h10); end
        run(1);
        nvec++; if (dut.pc.count !== 32'h0) begin nfail++; $display("FAIL j_target got %h want %h", dut.pc.count, 32'h0); end
        hold_reset();
        dut.imem.memory[0] = 32'h21080001;  // addi $t0,$t0,1, refetched after wrap
        release_reset();
        run(65);
        nvec++; if (dut.pc.count !== 32'h104) begin nfail++; $display("FAIL wrap_pc got %h want %h", dut.pc.count, 32'h104); end
        nvec++; if (dut.rfile.register[8] !== 32'd2) begin nfail++; $display("FAIL wrap_fetch got %h want %h", dut.rfile.register[8], 32'd2); end
    endtask

    task automatic test_async_reset();
        hold_reset();
        dut.imem.memory[0] = 32'h20080005;  // addi $t0,$zero,5
        dut.imem.memory[1] = 32'hAC080008;  // sw   $t0,8($zero)
        release_reset();
        run(5);
        nvec++; if (dut.pc.count !== 32'h14) begin nfail++; $display("FAIL ar_pre_pc got %h want %h", dut.pc.count, 32'h14); end
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        nvec++; if (dut.pc.count !== 32'h0) begin nfail++; $display("FAIL ar_pc got %h want %h", dut.pc.count, 32'h0); end
        nvec++; if (dut.rfile.register[8] !== 32'h0) begin nfail++; $display("FAIL ar_r8 got %h want %h", dut.rfile.register[8], 32'h0); end
        nvec++; if (dword(8) !== 32'd5) begin nfail++; $display("FAIL ar_dmem got %h want %h", dword(8), 32'd5); end
        #1.5 rst_n = 1'b1;
        run(1);
        nvec++; if (dut.pc.count !== 32'h4) begin nfail++; $display("FAIL ar_restart_pc got %h want %h", dut.pc.count, 32'h4); end
        nvec++; if (dut.rfile.register[8] !== 32'd5) begin nfail++; $display("FAIL ar_restart_r8 got %h want %h", dut.rfile.register[8], 32'd5); end
    endtask

    task automatic test_bne();
        logic [31:0] exp_pc;
`ifdef CPU_BNE_EN
        exp_pc = 32'd16;
`else
        exp_pc = 32'd8;
`endif
        hold_reset();
        dut.imem.memory[0] = 32'h20080005;  // addi $t0,$zero,5
        dut.imem.memory[1] = 32'h15000002;  // bne  $t0,$zero,+2
        release_reset();
        run(2);
        nvec++; if (dut.pc.count !== exp_pc) begin nfail++; $display("FAIL bne_pc got %h want %h", dut.pc.count, exp_pc); end
    endtask

    initial begin
        test_reset();
        test_load_store();
        test_alu();
        test_zero_reg();
        test_branch_jump();
        test_async_reset();
        test_bne();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
